// File: rtl/instruction_fetch.sv
// Instruction fetch unit: reads each 16-bit instruction as two byte reads (high byte first) and strobes it into the IR.
// Optional ack timeout with sticky fault flag is enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch #(
  parameter int                     PC_WIDTH       = 12,
  parameter logic [PC_WIDTH-1:0]    RESET_PC       = '0,
  parameter int                     TIMEOUT_CYCLES = 15
) (
  input  logic                clk_in,
  input  logic                reset_n_in,
  input  logic                fetch_req_in,
  input  logic                pc_load_en_in,
  input  logic [PC_WIDTH-1:0] pc_load_data_in,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                mem_req_out,
  output logic [PC_WIDTH:0]   mem_addr_out,
  input  logic                mem_ack_in,
  input  logic [7:0]          mem_data_in,
  output logic                ir_write_en_out,
  output logic [15:0]         ir_data_out,
  output logic                busy_out,
  output logic                fault_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ_HI = 2'd1;
  localparam logic [1:0] S_REQ_LO = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                pend_en_q, pend_en_d;
  logic [PC_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [7:0]          hi_q, hi_d;
  logic [15:0]         ir_q, ir_d;
  logic                timeout;
  logic                in_req;

  assign in_req = (state_q == S_REQ_HI) || (state_q == S_REQ_LO);

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  // Timeout fires on the last allowed cycle of a byte wait, so the byte gets exactly TIMEOUT_CYCLES cycles.
  assign timeout = in_req && !mem_ack_in && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d   = '0;
    fault_d = fault_q;
    if (in_req && (state_d == state_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (timeout) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign fault_out = fault_q;
`else
  assign timeout   = 1'b0;
  assign fault_out = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_en_d = pend_en_q;
    pend_pc_d = pend_pc_q;
    hi_d      = hi_q;
    ir_d      = ir_q;
    case (state_q)
      S_IDLE: begin
        if (pc_load_en_in) begin
          pc_d = pc_load_data_in;
        end
        if (fetch_req_in) begin
          state_d = S_REQ_HI;
        end
      end
      S_REQ_HI: begin
        if (pc_load_en_in) begin
          pend_en_d = 1'b1;
          pend_pc_d = pc_load_data_in;
        end
        if (mem_ack_in) begin
          hi_d    = mem_data_in;
          state_d = S_REQ_LO;
        end else if (timeout) begin
          ir_d    = 16'h0000;
          state_d = S_DONE;
        end
      end
      S_REQ_LO: begin
        if (pc_load_en_in) begin
          pend_en_d = 1'b1;
          pend_pc_d = pc_load_data_in;
        end
        if (mem_ack_in) begin
          ir_d    = {hi_q, mem_data_in};
          state_d = S_DONE;
        end else if (timeout) begin
          ir_d    = 16'h0000;
          state_d = S_DONE;
        end
      end
      default: begin
        // A branch arriving in DONE itself overrides one that was parked during the fetch.
        if (pc_load_en_in) begin
          pc_d = pc_load_data_in;
        end else if (pend_en_q) begin
          pc_d = pend_pc_q;
        end else begin
          pc_d = pc_q + 1'b1;
        end
        pend_en_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      pend_en_q <= 1'b0;
      pend_pc_q <= '0;
      hi_q      <= 8'h00;
      ir_q      <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_en_q <= pend_en_d;
      pend_pc_q <= pend_pc_d;
      hi_q      <= hi_d;
      ir_q      <= ir_d;
    end
  end

  assign pc_out          = pc_q;
  assign mem_req_out     = in_req;
  assign mem_addr_out    = {pc_q, (state_q == S_REQ_LO)};
  assign ir_write_en_out = (state_q == S_DONE);
  assign ir_data_out     = ir_q;
  assign busy_out        = (state_q != S_IDLE);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, hand sequences, and randomized fetches
// checked against a byte-memory reference model.
module tb_instruction_fetch;

  localparam int PW = 12;

  logic          clk_in = 1'b0;
  logic          reset_n_in;
  logic          fetch_req_in;
  logic          pc_load_en_in;
  logic [PW-1:0] pc_load_data_in;
  logic [PW-1:0] pc_out;
  logic          mem_req_out;
  logic [PW:0]   mem_addr_out;
  logic          mem_ack_in;
  logic [7:0]    mem_data_in;
  logic          ir_write_en_out;
  logic [15:0]   ir_data_out;
  logic          busy_out;
  logic          fault_out;

  int errors = 0;
  int checks = 0;

  logic [7:0]    mem [0:8191];
  logic [PW-1:0] pcModel;
  logic          faultModel;

  typedef struct {
    logic          loadEn;
    logic [PW-1:0] loadVal;
    int            hiWait;
    int            loWait;
    logic          hiBrEn;
    logic [PW-1:0] hiBrVal;
    logic          loBrEn;
    logic [PW-1:0] loBrVal;
    logic          doneBrEn;
    logic [PW-1:0] doneBrVal;
    logic          holdReq;
    logic [15:0]   expWord;
    logic [PW-1:0] expPc;
    int            expBusy;
  } vec_t;

  vec_t vecs [7];

  always #5 clk_in = ~clk_in;

  instruction_fetch #(.PC_WIDTH(PW), .RESET_PC('0), .TIMEOUT_CYCLES(15)) dut (
    .clk_in          (clk_in),
    .reset_n_in      (reset_n_in),
    .fetch_req_in    (fetch_req_in),
    .pc_load_en_in   (pc_load_en_in),
    .pc_load_data_in (pc_load_data_in),
    .pc_out          (pc_out),
    .mem_req_out     (mem_req_out),
    .mem_addr_out    (mem_addr_out),
    .mem_ack_in      (mem_ack_in),
    .mem_data_in     (mem_data_in),
    .ir_write_en_out (ir_write_en_out),
    .ir_data_out     (ir_data_out),
    .busy_out        (busy_out),
    .fault_out       (fault_out)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic fr, input logic le, input logic [PW-1:0] ld,
                               input logic ack, input logic [7:0] data);
    fetch_req_in    = fr;
    pc_load_en_in   = le;
    pc_load_data_in = ld;
    mem_ack_in      = ack;
    mem_data_in     = data;
  endtask

  // Drives one complete fetch as a bus slave with the given ack delays and branch injections.
  task automatic doFetch(input vec_t v, input string tag);
    logic [PW-1:0] fpc;
    logic [PW:0]   hiAddr, loAddr;
    logic [15:0]   word;
    logic          le, ack, fr, pcMoved;
    logic [PW-1:0] ld;
    logic [7:0]    data;
    int hiCnt, loCnt, busyCnt, strobes, cyc;
    bit done;
    fpc = v.loadEn ? v.loadVal : pcModel;
    hiAddr = 'x; loAddr = 'x; word = 'x; pcMoved = 1'b0;
    hiCnt = 0; loCnt = 0; busyCnt = 0; strobes = 0; cyc = 0; done = 0;
    @(negedge clk_in);
    applyStimulus(1'b1, v.loadEn, v.loadVal, 1'b0, 8'h00);
    while (!done && cyc < 200) begin
      @(negedge clk_in);
      cyc++;
      fr = v.holdReq; le = 1'b0; ld = '0; ack = 1'b0; data = 8'h00;
      if (busy_out) begin
        busyCnt++;
        if (pc_out !== fpc) pcMoved = 1'b1;
      end
      if (mem_req_out) begin
        if (mem_addr_out[0] == 1'b0) begin
          hiAddr = mem_addr_out;
          if (hiCnt == 0 && v.hiBrEn) begin le = 1'b1; ld = v.hiBrVal; end
          if (hiCnt == v.hiWait) begin ack = 1'b1; data = mem[mem_addr_out]; end
          hiCnt++;
        end else begin
          loAddr = mem_addr_out;
          if (loCnt == 0 && v.loBrEn) begin le = 1'b1; ld = v.loBrVal; end
          if (loCnt == v.loWait) begin ack = 1'b1; data = mem[mem_addr_out]; end
          loCnt++;
        end
      end
      if (ir_write_en_out) begin
        strobes++;
        word = ir_data_out;
        if (v.doneBrEn) begin le = 1'b1; ld = v.doneBrVal; end
      end
      if (!busy_out) begin
        fr = 1'b0;
        done = 1;
      end
      applyStimulus(fr, le, ld, ack, data);
    end
    if (!done) checkOutput({tag, "_completion_bound"}, 32'd0, 32'd1);
    checkOutput({tag, "_hi_addr"}, 32'(hiAddr), 32'({fpc, 1'b0}));
    checkOutput({tag, "_lo_addr"}, 32'(loAddr), 32'({fpc, 1'b1}));
    checkOutput({tag, "_strobes"}, 32'(strobes), 32'd1);
    checkOutput({tag, "_strobe_word"}, 32'(word), 32'(v.expWord));
    checkOutput({tag, "_ir_hold"}, 32'(ir_data_out), 32'(v.expWord));
    checkOutput({tag, "_busy_cycles"}, 32'(busyCnt), 32'(v.expBusy));
    checkOutput({tag, "_pc_stable"}, 32'(pcMoved), 32'd0);
    checkOutput({tag, "_next_pc"}, 32'(pc_out), 32'(v.expPc));
    checkOutput({tag, "_fault"}, 32'(fault_out), 32'(faultModel));
    @(negedge clk_in);
    checkOutput({tag, "_no_requeue"}, 32'({busy_out, ir_write_en_out}), 32'd0);
    pcModel = v.expPc;
  endtask

  function automatic vec_t modelVec(input logic loadEn, input logic [PW-1:0] loadVal, input int hw, input int lw,
                                    input logic hbE, input logic [PW-1:0] hbV, input logic lbE, input logic [PW-1:0] lbV,
                                    input logic dbE, input logic [PW-1:0] dbV, input logic hold);
    vec_t v;
    logic [PW-1:0] fpc;
    fpc = loadEn ? loadVal : pcModel;
    v = '{loadEn, loadVal, hw, lw, hbE, hbV, lbE, lbV, dbE, dbV, hold, 16'h0, '0, 0};
    v.expWord = {mem[{fpc, 1'b0}], mem[{fpc, 1'b1}]};
    if (dbE)      v.expPc = dbV;
    else if (lbE) v.expPc = lbV;
    else if (hbE) v.expPc = hbV;
    else          v.expPc = fpc + 1'b1;
    v.expBusy = hw + lw + 3;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_time_limit: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    mem[13'h0000] = 8'h12; mem[13'h0001] = 8'h34;
    mem[13'h0002] = 8'h56; mem[13'h0003] = 8'h78;
    mem[13'h00A0] = 8'h9A; mem[13'h00A1] = 8'hBC;
    mem[13'h1FFE] = 8'hAB; mem[13'h1FFF] = 8'hCD;
    mem[13'h0020] = 8'hDE; mem[13'h0021] = 8'hAD;
    mem[13'h0888] = 8'hBE; mem[13'h0889] = 8'hEF;
    mem[13'h0444] = 8'h0F; mem[13'h0445] = 8'hF0;

    //         load  loadVal hw lw hiBr  hiVal   loBr  loVal   dnBr  dnVal   hold  word      pc      busy
    vecs[0] = '{1'b0, 12'h000, 0, 0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 16'h1234, 12'h001, 3};
    vecs[1] = '{1'b0, 12'h000, 5, 5, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 16'h5678, 12'h002, 13};
    vecs[2] = '{1'b1, 12'h050, 1, 2, 1'b0, 12'h000, 1'b1, 12'h0A5, 1'b0, 12'h000, 1'b0, 16'h9ABC, 12'h0A5, 6};
    vecs[3] = '{1'b1, 12'hFFF, 0, 1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 16'hABCD, 12'h000, 4};
    vecs[4] = '{1'b1, 12'h010, 2, 0, 1'b1, 12'h333, 1'b1, 12'h444, 1'b0, 12'h000, 1'b0, 16'hDEAD, 12'h444, 5};
    vecs[5] = '{1'b0, 12'h000, 0, 0, 1'b1, 12'h111, 1'b0, 12'h000, 1'b1, 12'h222, 1'b0, 16'hBEEF, 12'h222, 3};
    vecs[6] = '{1'b0, 12'h000, 0, 0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 16'h0FF0, 12'h223, 3};

    faultModel = 1'b0;
    pcModel    = '0;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 8'h00);
    reset_n_in = 1'b0;
    #1;
    checkOutput("reset_pc", 32'(pc_out), 32'h0);
    checkOutput("reset_outputs", 32'({mem_req_out, ir_write_en_out, busy_out, fault_out}), 32'h0);
    checkOutput("reset_ir", 32'(ir_data_out), 32'h0);
    repeat (2) @(negedge clk_in);
    reset_n_in = 1'b1;

    for (int i = 0; i < 7; i++) doFetch(vecs[i], $sformatf("vec%0d", i));

    // Ack without a request must be ignored.
    @(negedge clk_in);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 8'hFF);
    @(negedge clk_in);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 8'h00);
    checkOutput("stray_ack_idle", 32'({busy_out, ir_write_en_out, mem_req_out}), 32'h0);
    checkOutput("stray_ack_ir", 32'(ir_data_out), 32'h0FF0);
    checkOutput("stray_ack_pc", 32'(pc_out), 32'(pcModel));

    for (int i = 0; i < 40; i++) begin
      vec_t rv;
      rv = modelVec(($urandom_range(0, 3) == 0), PW'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0), PW'($urandom), ($urandom_range(0, 3) == 0), PW'($urandom),
                    ($urandom_range(0, 3) == 0), PW'($urandom), 1'($urandom));
      doFetch(rv, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of REQ_HI abandons the fetch without waiting for a clock edge.
    @(negedge clk_in);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 8'h00);
    @(negedge clk_in);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 8'h00);
    checkOutput("midreset_req_before", 32'(mem_req_out), 32'd1);
    #2 reset_n_in = 1'b0;
    #1;
    checkOutput("midreset_req_drop", 32'(mem_req_out), 32'd0);
    checkOutput("midreset_busy", 32'(busy_out), 32'd0);
    checkOutput("midreset_pc", 32'(pc_out), 32'h0);
    checkOutput("midreset_ir", 32'(ir_data_out), 32'h0);
    @(negedge clk_in);
    reset_n_in = 1'b1;
    begin
      int strobeSeen;
      strobeSeen = 0;
      repeat (4) begin
        @(negedge clk_in);
        if (ir_write_en_out || busy_out) strobeSeen++;
      end
      checkOutput("midreset_no_strobe", 32'(strobeSeen), 32'd0);
    end
    pcModel = '0;
    doFetch(vecs[0], "post_reset");

`ifdef FETCH_TIMEOUT_EN
    begin
      int reqCycles, cyc;
      bit strobe;
      logic [15:0] tw;
      reqCycles = 0; cyc = 0; strobe = 0; tw = 'x;
      @(negedge clk_in);
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 8'h00);
      while (!strobe && cyc < 100) begin
        @(negedge clk_in);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 8'h00);
        cyc++;
        if (mem_req_out) reqCycles++;
        if (ir_write_en_out) begin strobe = 1; tw = ir_data_out; end
      end
      checkOutput("timeout_strobe", 32'(strobe), 32'd1);
      checkOutput("timeout_req_cycles", 32'(reqCycles), 32'd15);
      checkOutput("timeout_nop", 32'(tw), 32'h0);
      @(negedge clk_in);
      checkOutput("timeout_fault", 32'(fault_out), 32'd1);
      checkOutput("timeout_pc", 32'(pc_out), 32'(pcModel + 1'b1));
      pcModel    = pcModel + 1'b1;
      faultModel = 1'b1;
      doFetch(modelVec(1'b0, '0, 1, 1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0), "after_timeout");
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
